byte_ram_responder: RTL and testbench

- Responder end of the core's byte-wide memory bus: answers the byte-serial initiator's `mem_a`/`mem_wr`/`mem_dout` with `mem_din` one cycle after each accepted access.
- Holds a synchronous byte RAM plus a small I/O window with a transmit FIFO and a receive FIFO.
- Drives the shared `rdy` stall so that I/O accesses the FIFOs cannot honour are held on the bus until they can.
- Sits between the core's memory accesser and the board-level RAM and serial link.

---
 rtl/byte_ram_responder_pkg.sv | 27 ++
 rtl/byte_ram_responder_if.sv | 14 +
 rtl/byte_ram_responder_byte_fifo.sv | 49 ++++
 rtl/byte_ram_responder.sv | 99 +++++++++
 tb/tb_byte_ram_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_ram_responder_pkg.sv
// Shared constants and address decode for the byte-wide memory responder.
// Region selection uses mem_a[17:16]; I/O register selection uses mem_a[2].
package byte_ram_responder_pkg;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_DATA_OFF = 3'd0;
  localparam logic [2:0] IO_STAT_OFF = 3'd4;
  localparam int         IO_OFF_BIT  = 2;

  localparam int STAT_RXNE = 0;
  localparam int STAT_TXF  = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } region_e;

  function automatic region_e decode_region(input logic [1:0] sel);
    region_e r;
    if (sel == IO_SEL)   r = REGION_IO;
    else if (!sel[1])    r = REGION_RAM;
    else                 r = REGION_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/byte_ram_responder_if.sv
// Byte-wide memory bus between the serial initiator and the responder.
// Handshake: the initiator presents mem_a/mem_wr/mem_dout every cycle; an access
// is performed at each rising edge where rdy=1, and while rdy=0 the initiator
// holds all three unchanged. mem_din answers an accepted read one cycle later.
interface byte_ram_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy;

  modport master (output mem_a, mem_wr, mem_dout, input mem_din, rdy);
  modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, rdy);
endinterface

// File: rtl/byte_ram_responder_byte_fifo.sv
// Circular byte FIFO with separate read/write pointers and an occupancy count.
// Flags come from the registered count; head reads 0 while the FIFO is empty.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/byte_ram_responder.sv
// Responder for the core's byte-wide memory bus: synchronous byte RAM plus an
// I/O window whose DATA register fronts a TX FIFO (writes) and an RX FIFO (reads).
module byte_ram_responder
  import byte_ram_responder_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_ram_responder_if.slave  bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
);

  logic [7:0]        ram [2**ADDR_W];
  logic [ADDR_W-1:0] ram_idx;
  region_e           region;
  logic              is_data;
  logic              rdy;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]        rx_head;
  logic [7:0]        status_byte;
  logic [7:0]        rd_data;
  logic [7:0]        mem_din_q;
  logic              unused_addr;

  assign unused_addr = ^bus.mem_a[31:18];
  assign ram_idx     = bus.mem_a[ADDR_W-1:0];
  assign region      = decode_region(bus.mem_a[17:16]);
  assign is_data     = (region == REGION_IO) &&
                       (bus.mem_a[IO_OFF_BIT] == IO_DATA_OFF[IO_OFF_BIT]);

  // Stall only DATA accesses the FIFOs cannot honour, judged on pre-edge flags.
  assign rdy     = rst && !(is_data && (bus.mem_wr ? tx_full : rx_empty));
  assign bus.rdy = rdy;

  assign tx_push  = rdy && is_data && bus.mem_wr;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rdy && is_data && !bus.mem_wr;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (bus.mem_dout),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    status_byte            = 8'h00;
    status_byte[STAT_TXF]  = tx_full;
    status_byte[STAT_RXNE] = !rx_empty;
  end

  always_comb begin
    rd_data = 8'h00;
    case (region)
      REGION_RAM: rd_data = ram[ram_idx];
      REGION_IO:  rd_data = is_data ? rx_head : status_byte;
      default:    rd_data = 8'h00;
    endcase
  end

  // RAM contents survive reset; only the bus-side state is cleared.
  always_ff @(posedge clk) begin
    if (rdy && bus.mem_wr && (region == REGION_RAM)) ram[ram_idx] <= bus.mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      mem_din_q <= 8'h00;
    else if (rdy && !bus.mem_wr)   mem_din_q <= rd_data;
  end

  assign bus.mem_din = mem_din_q;

endmodule

// File: tb/tb_byte_ram_responder.sv
// Directed bench for byte_ram_responder: a vector table for plain RAM/status
// accesses, then hand-written sequences for FIFO stalls, concurrency and reset.
module tb_byte_ram_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  byte_ram_responder_if bus ();

  byte_ram_responder #(.ADDR_W(17), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic [7:0]  din;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic [7:0] dout,
                              input logic [7:0] din, input string name);
    vec_t v;
    v.a = a; v.wr = wr; v.dout = dout; v.din = din; v.name = name;
    return v;
  endfunction

  // Driver tasks
  task automatic set_bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    set_bus(32'h0002_0000, 1'b0, 8'h00);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_din", bus.mem_din, 8'h00);
    check("rst_rdy", bus.rdy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b1);
    rst = 1'b1;
    #1;
    check("rdy_after_rst", bus.rdy, 1'b1);
    tick();

    // Table: RAM round-trip, RAM top, aliasing, unmapped, status
    vecs.push_back(mk(32'h0000_0010, 1'b1, 8'hA5, 8'h00, "ram_wr_10"));
    vecs.push_back(mk(32'h0000_0010, 1'b0, 8'h00, 8'hA5, "ram_rd_10"));
    vecs.push_back(mk(32'h0000_FFFF, 1'b1, 8'h3C, 8'hA5, "ram_wr_0ffff"));
    vecs.push_back(mk(32'h0001_FFFF, 1'b1, 8'hC3, 8'hA5, "ram_wr_1ffff"));
    vecs.push_back(mk(32'h0000_FFFF, 1'b0, 8'h00, 8'h3C, "ram_rd_0ffff"));
    vecs.push_back(mk(32'h0001_FFFF, 1'b0, 8'h00, 8'hC3, "ram_rd_1ffff"));
    vecs.push_back(mk(32'h0002_0010, 1'b1, 8'h77, 8'hC3, "unmap_wr"));
    vecs.push_back(mk(32'h0002_0010, 1'b0, 8'h00, 8'h00, "unmap_rd"));
    vecs.push_back(mk(32'hFFFC_0010, 1'b0, 8'h00, 8'hA5, "ram_alias_rd"));
    vecs.push_back(mk(32'h0003_0004, 1'b0, 8'h00, 8'h00, "stat_rd_idle"));
    vecs.push_back(mk(32'h0000_0010, 1'b0, 8'h00, 8'hA5, "ram_rd_10b"));
    vecs.push_back(mk(32'h0003_0004, 1'b1, 8'hFF, 8'hA5, "stat_wr_ignored"));
    vecs.push_back(mk(32'h0003_0004, 1'b0, 8'h00, 8'h00, "stat_rd_idle2"));
    for (int i = 0; i < vecs.size(); i++) begin
      set_bus(vecs[i].a, vecs[i].wr, vecs[i].dout);
      #1;
      check({vecs[i].name, "_rdy"}, bus.rdy, 1'b1);
      tick();
      check(vecs[i].name, bus.mem_din, vecs[i].din);
    end
    check("tx_idle_after_table", tx_valid, 1'b0);

    // TX fill, full stall, single pop releases one cycle later
    for (int i = 1; i <= 4; i++) begin
      set_bus(32'h0003_0000, 1'b1, i[7:0]);
      #1;
      check("tx_fill_rdy", bus.rdy, 1'b1);
      tick();
      exp_q.push_back(i[7:0]);
      if (i == 1) begin
        check("tx_valid_first", tx_valid, 1'b1);
        check("tx_data_first", tx_data, 8'h01);
      end
    end
    set_bus(32'h0003_0000, 1'b1, 8'h05);
    #1;
    check("tx_full_stall", bus.rdy, 1'b0);
    tick();
    check("tx_stall_hold", bus.rdy, 1'b0);
    tx_ready = 1'b1;
    #1;
    check("tx_pop_no_release", bus.rdy, 1'b0);
    check("tx_head_taken", tx_data, exp_q.pop_front());
    tick();
    tx_ready = 1'b0;
    #1;
    check("tx_release", bus.rdy, 1'b1);
    tick();
    exp_q.push_back(8'h05);
    set_bus(32'h0000_0010, 1'b0, 8'h00);
    tx_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (!tx_valid) break;
      if (exp_q.size() > 0) check("tx_drain", tx_data, exp_q.pop_front());
      n++;
      tick();
    end
    tx_ready = 1'b0;
    check("tx_drain_count", n, 4);
    check("tx_drain_empty", tx_valid, 1'b0);

    // RX empty stall released by an upstream push
    set_bus(32'h0003_0000, 1'b0, 8'h00);
    #1;
    check("rx_empty_stall", bus.rdy, 1'b0);
    tick();
    check("din_hold_stall", bus.mem_din, 8'hA5);
    rx_data  = 8'h7E;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("rx_release", bus.rdy, 1'b1);
    check("din_hold_release", bus.mem_din, 8'hA5);
    tick();
    check("rx_pop_data", bus.mem_din, 8'h7E);
    set_bus(32'h0000_FFFF, 1'b0, 8'h00);
    tick();
    check("ram_rd_after_rx", bus.mem_din, 8'h3C);

    // RX full with simultaneous push and bus pop
    for (int i = 0; i < 4; i++) begin
      rx_data  = 8'h11 + 8'(i);
      rx_valid = 1'b1;
      tick();
      check("rx_fill_ready", rx_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    rx_data = 8'h15;
    set_bus(32'h0003_0000, 1'b0, 8'h00);
    #1;
    check("rx_full_pop_rdy", bus.rdy, 1'b1);
    tick();
    check("rx_conc_pop", bus.mem_din, 8'h11);
    check("rx_ready_after_pop", rx_ready, 1'b1);
    set_bus(32'h0001_FFFF, 1'b0, 8'h00);
    tick();
    rx_valid = 1'b0;
    check("rx_pending_accepted", rx_ready, 1'b0);
    check("ram_rd_during_rx", bus.mem_din, 8'hC3);
    for (int b = 8'h12; b <= 8'h15; b++) begin
      set_bus(32'h0003_0000, 1'b0, 8'h00);
      #1;
      check("rx_drain_rdy", bus.rdy, 1'b1);
      tick();
      check("rx_drain", bus.mem_din, b[7:0]);
    end
    set_bus(32'h0000_0010, 1'b0, 8'h00);
    check("rx_ready_drained", rx_ready, 1'b1);
    tick();

    // STATUS with TX full and one RX byte, then reset during a TX-full stall
    for (int i = 0; i < 4; i++) begin
      set_bus(32'h0003_0000, 1'b1, 8'hB0 + 8'(i));
      tick();
    end
    set_bus(32'h0000_0010, 1'b0, 8'h00);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    set_bus(32'h0003_0004, 1'b0, 8'h00);
    #1;
    check("stat_rdy", bus.rdy, 1'b1);
    tick();
    check("stat_full", bus.mem_din, 8'h03);
    set_bus(32'h0003_0000, 1'b1, 8'hEE);
    #1;
    check("stall_before_reset", bus.rdy, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_mem_din", bus.mem_din, 8'h00);
    check("midrst_rdy", bus.rdy, 1'b0);
    check("midrst_rx_ready", rx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    set_bus(32'h0000_0010, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check("post_rst_rdy", bus.rdy, 1'b1);
    tick();
    check("ram_kept", bus.mem_din, 8'hA5);
    set_bus(32'h0003_0004, 1'b0, 8'h00);
    tick();
    check("stat_after_reset", bus.mem_din, 8'h00);
    check("tx_empty_after_reset", tx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
